// File: rtl/pwm_pkg.sv
// Shared types for the multilevel PWM configuration sequencer.
// Holds the sequencer states, the per-level config bundle and an index-width helper.
package pwm_pkg;

    localparam int unsigned PWM_BW = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIV1,
        ST_DIV2,
        ST_LIMITS,
        ST_RUN
    } seq_state_t;

    typedef struct packed {
        logic [PWM_BW-1:0] lower;
        logic [PWM_BW-1:0] upper;
        logic [PWM_BW-1:0] offset;
    } lvl_cfg_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pwm_level_sequencer_if.sv
// Control/status and level-bank bus between the sequencer and its host.
// The host side drives Start/Stop/PWMMaxCount; the sequencer drives the rest.
interface pwm_level_sequencer_if #(
    parameter int unsigned LevelCount = 2,
    parameter int unsigned BIT_WIDTH  = 16
) ();

    logic                            Start;
    logic                            Stop;
    logic [BIT_WIDTH-1:0]            PWMMaxCount;
    logic                            Ready;
    logic                            Busy;
    logic                            Done;
    logic                            CfgErr;
    logic                            LevelEn;
    logic [LevelCount*BIT_WIDTH-1:0] LowerLimit;
    logic [LevelCount*BIT_WIDTH-1:0] UpperLimit;
    logic [LevelCount*BIT_WIDTH-1:0] InterleaveOffset;

    modport master (
        output Start,
        output Stop,
        output PWMMaxCount,
        input  Ready,
        input  Busy,
        input  Done,
        input  CfgErr,
        input  LevelEn,
        input  LowerLimit,
        input  UpperLimit,
        input  InterleaveOffset
    );

    modport slave (
        input  Start,
        input  Stop,
        input  PWMMaxCount,
        output Ready,
        output Busy,
        output Done,
        output CfgErr,
        output LevelEn,
        output LowerLimit,
        output UpperLimit,
        output InterleaveOffset
    );

endinterface

// File: rtl/pwm_level_sequencer_seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per edge.
// The start edge performs the first step, so o_done pulses BIT_WIDTH-1 edges later.
module seq_divider #(
    parameter int unsigned BIT_WIDTH = 16
) (
    input  logic                 MClk,
    input  logic                 Rst,
    input  logic                 i_start,
    input  logic [BIT_WIDTH-1:0] i_dividend,
    input  logic [BIT_WIDTH-1:0] i_divisor,
    output logic                 o_done,
    output logic [BIT_WIDTH-1:0] o_quotient
);

    localparam int unsigned CW = $clog2(BIT_WIDTH + 1);

    logic [BIT_WIDTH:0]   r_rem;
    logic [BIT_WIDTH-1:0] r_quo;
    logic [CW-1:0]        r_cnt;
    logic                 r_busy;
    logic                 r_done;

    logic [BIT_WIDTH:0]   w_src_rem;
    logic [BIT_WIDTH-1:0] w_src_quo;
    logic [BIT_WIDTH+1:0] w_sh;
    logic [BIT_WIDTH+1:0] w_dvs;
    logic                 w_ge;
    logic [BIT_WIDTH:0]   w_rem_n;
    logic [BIT_WIDTH-1:0] w_quo_n;

    always_comb begin
        w_src_rem = i_start ? '0 : r_rem;
        w_src_quo = i_start ? i_dividend : r_quo;
        w_sh      = {w_src_rem, w_src_quo[BIT_WIDTH-1]};
        w_dvs     = {2'b00, i_divisor};
        w_ge      = (w_sh >= w_dvs);
        w_rem_n   = w_ge ? (BIT_WIDTH+1)'(w_sh - w_dvs) : w_sh[BIT_WIDTH:0];
        w_quo_n   = {w_src_quo[BIT_WIDTH-2:0], w_ge};
    end

    always_ff @(posedge MClk) begin
        if (Rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem  <= w_rem_n;
                r_quo  <= w_quo_n;
                r_cnt  <= CW'(BIT_WIDTH - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_rem_n;
                r_quo <= w_quo_n;
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done     = r_done;
    assign o_quotient = r_quo;

endmodule

// File: rtl/pwm_level_sequencer.sv
// Computes per-level carrier windows and interleave offsets from one period count,
// then releases every level cell together with a single enable.
module pwm_level_sequencer
    import pwm_pkg::*;
#(
    parameter int unsigned LevelCount = 2,
    parameter int unsigned BIT_WIDTH  = PWM_BW
) (
    input logic                  MClk,
    input logic                  Rst,
    pwm_level_sequencer_if.slave bus
);

    localparam int unsigned IDXW = idx_w(LevelCount);
    localparam int unsigned VW   = LevelCount * BIT_WIDTH;

    seq_state_t           r_state;
    seq_state_t           w_state;
    logic [BIT_WIDTH-1:0] r_P;
    logic [BIT_WIDTH-1:0] r_Q;
    logic [BIT_WIDTH-1:0] r_S;
    logic [BIT_WIDTH-1:0] r_accL;
    logic [BIT_WIDTH-1:0] r_accO;
    logic [IDXW-1:0]      r_idx;
    logic                 r_div_go;
    logic                 r_cfg_err;
    logic [VW-1:0]        r_lo;
    logic [VW-1:0]        r_hi;
    logic [VW-1:0]        r_off;

    logic                 w_accept;
    logic                 w_err;
    logic                 w_div_start;
    logic                 w_latch_q;
    logic                 w_latch_s;
    logic                 w_write;
    logic                 w_go;
    logic                 w_div_done;
    logic [BIT_WIDTH-1:0] w_dividend;
    logic [BIT_WIDTH-1:0] w_quo;
    lvl_cfg_t             w_cfg;

    // First divide starts the edge after acceptance from the latched P;
    // the second is chained straight off the first quotient.
    assign w_go       = r_div_go | w_div_start;
    assign w_dividend = r_div_go ? r_P : w_quo;

    seq_divider #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_div (
        .MClk       (MClk),
        .Rst        (Rst),
        .i_start    (w_go),
        .i_dividend (w_dividend),
        .i_divisor  (BIT_WIDTH'(LevelCount)),
        .o_done     (w_div_done),
        .o_quotient (w_quo)
    );

    always_ff @(posedge MClk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_accept    = 1'b0;
        w_err       = 1'b0;
        w_div_start = 1'b0;
        w_latch_q   = 1'b0;
        w_latch_s   = 1'b0;
        w_write     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.Start) begin
                    w_accept = 1'b1;
                    w_state  = ST_DIV1;
                end
            end
            ST_DIV1: begin
                if (w_div_done) begin
                    if (w_quo == '0) begin
                        w_err   = 1'b1;
                        w_state = ST_IDLE;
                    end else begin
                        w_latch_q   = 1'b1;
                        w_div_start = 1'b1;
                        w_state     = ST_DIV2;
                    end
                end
            end
            ST_DIV2: begin
                if (w_div_done) begin
                    w_latch_s = 1'b1;
                    w_state   = ST_LIMITS;
                end
            end
            ST_LIMITS: begin
                w_write = 1'b1;
                if (r_idx == IDXW'(LevelCount - 1)) begin
                    w_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.Stop) begin
                    w_state = ST_IDLE;
                end else if (bus.Start) begin
                    w_accept = 1'b1;
                    w_state  = ST_DIV1;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cfg        = '0;
        w_cfg.lower  = r_accL;
        w_cfg.upper  = r_accL + r_Q - BIT_WIDTH'(1);
        w_cfg.offset = r_accO;
    end

    always_ff @(posedge MClk) begin
        if (Rst) begin
            r_P       <= '0;
            r_Q       <= '0;
            r_S       <= '0;
            r_accL    <= '0;
            r_accO    <= '0;
            r_idx     <= '0;
            r_div_go  <= 1'b0;
            r_cfg_err <= 1'b0;
            r_lo      <= '0;
            r_hi      <= '0;
            r_off     <= '0;
        end else begin
            r_div_go <= w_accept;
            if (w_accept) begin
                r_P       <= bus.PWMMaxCount;
                r_cfg_err <= 1'b0;
            end
            if (w_err) begin
                r_cfg_err <= 1'b1;
            end
            if (w_latch_q) begin
                r_Q <= w_quo;
            end
            if (w_latch_s) begin
                r_S    <= w_quo;
                r_accL <= '0;
                r_accO <= '0;
                r_idx  <= '0;
            end
            if (w_write) begin
                r_lo[int'(r_idx)*BIT_WIDTH +: BIT_WIDTH]  <= w_cfg.lower;
                r_hi[int'(r_idx)*BIT_WIDTH +: BIT_WIDTH]  <= w_cfg.upper;
                r_off[int'(r_idx)*BIT_WIDTH +: BIT_WIDTH] <= w_cfg.offset;
                r_accL <= r_accL + r_Q;
                r_accO <= r_accO + r_S;
                r_idx  <= r_idx + IDXW'(1);
            end
        end
    end

    assign bus.Ready            = (r_state == ST_IDLE) || (r_state == ST_RUN);
    assign bus.Busy             = (r_state == ST_DIV1) || (r_state == ST_DIV2)
                                || (r_state == ST_LIMITS);
    assign bus.Done             = (r_state == ST_RUN);
    assign bus.LevelEn          = (r_state == ST_RUN);
    assign bus.CfgErr           = r_cfg_err;
    assign bus.LowerLimit       = r_lo;
    assign bus.UpperLimit       = r_hi;
    assign bus.InterleaveOffset = r_off;

endmodule
